// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared constants and elaboration-time helpers for seq_det_param
package seq_det_pkg;

  localparam int MAX_W = 16;

  localparam logic [3:0] PAT_1010 = 4'b1010;
  localparam logic [3:0] PAT_1011 = 4'b1011;
  localparam logic [3:0] PAT_0110 = 4'b0110;

  function automatic int state_w(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

  // Longest prefix of pattern (first bit at [width-1]) that is a suffix of the
  // clen-bit candidate (most recent bit at cand[0]).
  function automatic int match_len(input logic [15:0] pattern, input int width,
                                   input logic [15:0] cand, input int clen);
    int   best;
    logic ok;
    best = 0;
    for (int k = 1; k <= MAX_W; k++) begin
      if (k <= clen && k <= width) begin
        ok = 1'b1;
        for (int i = 0; i < MAX_W; i++) begin
          if (i < k && pattern[4'(width - 1 - i)] != cand[4'(k - 1 - i)]) ok = 1'b0;
        end
        if (ok) best = k;
      end
    end
    return best;
  endfunction

  // Longest proper prefix of pattern that is also its suffix.
  function automatic int fail_len(input logic [15:0] pattern, input int width);
    return match_len(pattern, width, pattern, width - 1);
  endfunction

endpackage

// File: rtl/seq_det_next.sv
// rtl/seq_det_next.sv - combinational next-state and match function of the detector
module seq_det_next
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = PAT_1010,
  parameter bit               OVERLAP = 1'b1,
  localparam int              SW      = state_w(PAT_W)
) (
  input  logic [SW-1:0] state,
  input  logic          x,
  output logic [SW-1:0] next_state,
  output logic          hit
);

  localparam logic [15:0] PAT16    = 16'(PATTERN);
  localparam int          FAIL_LEN = fail_len(PAT16, PAT_W);

  logic [15:0] cand;

  always_comb begin
    cand       = ((PAT16 >> (PAT_W - int'(state))) << 1) | 16'(x);
    hit        = 1'b0;
    next_state = '0;
    // The prefix is already matched, so a full match only needs the last bit.
    if (int'(state) == PAT_W - 1 && x == PATTERN[0]) begin
      hit        = 1'b1;
      next_state = OVERLAP ? SW'(FAIL_LEN) : '0;
    end else begin
      next_state = SW'(match_len(PAT16, PAT_W, cand, int'(state) + 1));
    end
  end

endmodule

// File: rtl/seq_det_param.sv
// rtl/seq_det_param.sv - parameterised serial pattern detector; SEQ_DET_CNT_EN adds a match counter
module seq_det_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = PAT_1010,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     x,
  input  logic                     en,
  output logic                     z,
  output logic [CNT_W-1:0]         match_cnt,
  output logic [state_w(PAT_W)-1:0] prefix_len
);

  localparam int SW = state_w(PAT_W);

  logic [SW-1:0] state;
  logic [SW-1:0] next_state;
  logic          hit;

  seq_det_next #(
    .PAT_W  (PAT_W),
    .PATTERN(PATTERN),
    .OVERLAP(OVERLAP)
  ) u_next (
    .state     (state),
    .x         (x),
    .next_state(next_state),
    .hit       (hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= '0;
      z     <= 1'b0;
    end else if (en) begin
      state <= next_state;
      z     <= hit;
    end else begin
      z     <= 1'b0;
    end
  end

  assign prefix_len = state;

`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en && hit && cnt != {CNT_W{1'b1}}) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign match_cnt = cnt;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_det_param.sv
// tb/tb_seq_det_param.sv - table-driven bench for seq_det_param over four parameter sets
module tb_seq_det_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic x   = 1'b0;
  logic en  = 1'b0;

  logic       z_def, z_nov, z_111, z_cnt;
  logic [7:0] cnt_def, cnt_nov, cnt_111;
  logic [1:0] cnt_cnt;
  logic [1:0] pl_def, pl_nov, pl_111, pl_cnt;

  always #5 clk = ~clk;

  seq_det_param #(.PAT_W(4), .PATTERN(4'b1010), .OVERLAP(1'b1), .CNT_W(8)) u_def (
    .clk(clk), .rst(rst), .x(x), .en(en), .z(z_def), .match_cnt(cnt_def), .prefix_len(pl_def));
  seq_det_param #(.PAT_W(4), .PATTERN(4'b1010), .OVERLAP(1'b0), .CNT_W(8)) u_nov (
    .clk(clk), .rst(rst), .x(x), .en(en), .z(z_nov), .match_cnt(cnt_nov), .prefix_len(pl_nov));
  seq_det_param #(.PAT_W(3), .PATTERN(3'b111), .OVERLAP(1'b1), .CNT_W(8)) u_111 (
    .clk(clk), .rst(rst), .x(x), .en(en), .z(z_111), .match_cnt(cnt_111), .prefix_len(pl_111));
  seq_det_param #(.PAT_W(4), .PATTERN(4'b1010), .OVERLAP(1'b1), .CNT_W(2)) u_cnt (
    .clk(clk), .rst(rst), .x(x), .en(en), .z(z_cnt), .match_cnt(cnt_cnt), .prefix_len(pl_cnt));

  typedef struct {
    int   sel;
    logic rst;
    logic en;
    logic x;
    logic z;
    int   plen;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(int sel, logic r, logic e, logic b, logic ez, int ep);
    vec_t v;
    v.sel = sel; v.rst = r; v.en = e; v.x = b; v.z = ez; v.plen = ep;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, int idx, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0d expected %0d", name, idx, got, exp);
    end
  endtask

  function automatic logic sel_z(int sel);
    case (sel)
      0: return z_def;
      1: return z_nov;
      2: return z_111;
      default: return z_cnt;
    endcase
  endfunction

  function automatic int sel_pl(int sel);
    case (sel)
      0: return int'(pl_def);
      1: return int'(pl_nov);
      2: return int'(pl_111);
      default: return int'(pl_cnt);
    endcase
  endfunction

  task automatic step(logic r, logic e, logic b);
    rst = r; en = e; x = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_cnt;
    int exp_pl;
    logic exp_z;

    // Test 1: default 1010 with overlap
    add(0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 1); add(0, 0, 1, 0, 0, 2); add(0, 0, 1, 1, 0, 3);
    add(0, 0, 1, 0, 1, 2); add(0, 0, 1, 1, 0, 3); add(0, 0, 1, 0, 1, 2);
    // Test 2: non-overlapping
    add(1, 1, 0, 0, 0, 0);
    add(1, 0, 1, 1, 0, 1); add(1, 0, 1, 0, 0, 2); add(1, 0, 1, 1, 0, 3); add(1, 0, 1, 0, 1, 0);
    add(1, 0, 1, 1, 0, 1); add(1, 0, 1, 0, 0, 2); add(1, 0, 1, 1, 0, 3); add(1, 0, 1, 0, 1, 0);
    // Test 3: 111 with overlap gives back-to-back pulses
    add(2, 1, 0, 0, 0, 0);
    add(2, 0, 1, 1, 0, 1); add(2, 0, 1, 1, 0, 2); add(2, 0, 1, 1, 1, 2);
    add(2, 0, 1, 1, 1, 2); add(2, 0, 1, 1, 1, 2); add(2, 0, 1, 0, 0, 0);
    // Test 4: en gap holds state and ignores x
    add(0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 1); add(0, 0, 1, 0, 0, 2); add(0, 0, 1, 1, 0, 3);
    add(0, 0, 0, 0, 0, 3); add(0, 0, 0, 1, 0, 3); add(0, 0, 0, 0, 0, 3);
    add(0, 0, 1, 0, 1, 2);
    // Test 5: reset mid-match (rst overrides en=1, x=0)
    add(0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 1); add(0, 0, 1, 0, 0, 2); add(0, 0, 1, 1, 0, 3);
    add(0, 1, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0); add(0, 0, 1, 1, 0, 1); add(0, 0, 1, 0, 0, 2);
    // Mismatch fallback: 1,1,0,1,1 falls back to prefix "1"
    add(0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 1); add(0, 0, 1, 1, 0, 1); add(0, 0, 1, 0, 0, 2);
    add(0, 0, 1, 1, 0, 3); add(0, 0, 1, 1, 0, 1);

    @(negedge clk);
    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].x);
      check("z", i, int'(sel_z(vecs[i].sel)), int'(vecs[i].z));
      check("prefix_len", i, sel_pl(vecs[i].sel), vecs[i].plen);
    end

    // Test 6: counter saturation over five 1010 groups
    step(1, 0, 0);
    check("cnt_def_rst", 0, int'(cnt_def), 0);
    check("cnt_nov_rst", 0, int'(cnt_nov), 0);
    check("cnt_111_rst", 0, int'(cnt_111), 0);
    check("cnt_cnt_rst", 0, int'(cnt_cnt), 0);
    exp_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      step(0, 1, (i % 2) == 1);
      exp_z  = (i >= 4) && (i % 2 == 0);
      exp_pl = (i <= 3) ? i : ((i % 2 == 0) ? 2 : 3);
`ifdef SEQ_DET_CNT_EN
      if (exp_z && exp_cnt < 3) exp_cnt++;
`endif
      check("cnt_z", i, int'(z_cnt), int'(exp_z));
      check("cnt_prefix_len", i, int'(pl_cnt), exp_pl);
      check("match_cnt", i, int'(cnt_cnt), exp_cnt);
    end
    step(1, 1, 0);
    check("match_cnt_after_rst", 21, int'(cnt_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
